// File: rtl/uart_program_loader.sv
// Boot loader: receives an 8N1 UART byte stream (16-bit little-endian word count, then
// little-endian 32-bit words), writes each word to memory, then raises top_en for good.
module uart_program_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [15:0] BASE_ADDR    = 16'd0
) (
    input  logic        fast_clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        mem_en,
    output logic        mem_wen,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        top_en,
    output logic        frame_err,
    output logic [15:0] words_loaded
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_HDR0,
        L_HDR1,
        L_WORD,
        L_WRITE,
        L_DONE
    } ld_state_t;

    // ---------------------------------------------------------------
    // Input synchronizer (idle-high line, so flops reset to 1)
    // ---------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic w_rx;

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rx = r_rx_sync;

    // ---------------------------------------------------------------
    // Receiver FSM
    // ---------------------------------------------------------------
    rx_state_t        r_rx_state;
    rx_state_t        w_rx_state_next;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_byte;
    logic             r_byte_valid;
    logic             r_frame_err;
    logic             w_cnt_done;
    logic             w_sample_bit;
    logic             w_stop_sample;

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            r_rx_state <= R_IDLE;
        end else begin
            r_rx_state <= w_rx_state_next;
        end
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_cnt_done      = 1'b0;
        w_sample_bit    = 1'b0;
        w_stop_sample   = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                if (!w_rx) begin
                    w_rx_state_next = R_START;
                end
            end
            R_START: begin
                // Half a bit in: a line that has gone high again was only a glitch.
                w_cnt_done = (r_clk_cnt == HALF_M1);
                if (w_cnt_done) begin
                    w_rx_state_next = w_rx ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                w_cnt_done   = (r_clk_cnt == FULL_M1);
                w_sample_bit = w_cnt_done;
                if (w_cnt_done && (r_bit_idx == 3'd7)) begin
                    w_rx_state_next = R_STOP;
                end
            end
            R_STOP: begin
                w_cnt_done    = (r_clk_cnt == FULL_M1);
                w_stop_sample = w_cnt_done;
                if (w_cnt_done) begin
                    w_rx_state_next = R_IDLE;
                end
            end
            default: begin
                w_rx_state_next = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_rx_byte    <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if ((r_rx_state == R_IDLE) || w_cnt_done) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end

            if (r_rx_state == R_IDLE) begin
                r_bit_idx <= '0;
            end else if (w_sample_bit) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            // LSB arrives first, so shift in from the top.
            if (w_sample_bit) begin
                r_shift <= {w_rx, r_shift[7:1]};
            end

            if (w_stop_sample && w_rx) begin
                r_rx_byte <= r_shift;
            end

            r_byte_valid <= w_stop_sample && w_rx;

            if (w_stop_sample && !w_rx) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Loader FSM
    // ---------------------------------------------------------------
    ld_state_t   r_ld_state;
    ld_state_t   w_ld_state_next;
    logic [15:0] r_count;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_word_asm;
    logic [15:0] r_words;
    logic [15:0] r_mem_addr;
    logic [31:0] r_mem_din;
    logic [15:0] w_words_inc;
    logic [15:0] w_count_full;

    assign w_words_inc  = r_words + 16'd1;
    assign w_count_full = {r_rx_byte, r_count[7:0]};

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            r_ld_state <= L_HDR0;
        end else begin
            r_ld_state <= w_ld_state_next;
        end
    end

    always_comb begin
        w_ld_state_next = r_ld_state;
        case (r_ld_state)
            L_HDR0: begin
                if (r_byte_valid) begin
                    w_ld_state_next = L_HDR1;
                end
            end
            L_HDR1: begin
                if (r_byte_valid) begin
                    w_ld_state_next = (w_count_full == 16'd0) ? L_DONE : L_WORD;
                end
            end
            L_WORD: begin
                if (r_byte_valid && (r_byte_idx == 2'd3)) begin
                    w_ld_state_next = L_WRITE;
                end
            end
            L_WRITE: begin
                w_ld_state_next = (w_words_inc == r_count) ? L_DONE : L_WORD;
            end
            L_DONE: begin
                w_ld_state_next = L_DONE;
            end
            default: begin
                w_ld_state_next = L_HDR0;
            end
        endcase
    end

    always_ff @(posedge fast_clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_byte_idx <= '0;
            r_word_asm <= '0;
            r_words    <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            case (r_ld_state)
                L_HDR0: begin
                    if (r_byte_valid) begin
                        r_count[7:0] <= r_rx_byte;
                    end
                end
                L_HDR1: begin
                    if (r_byte_valid) begin
                        r_count[15:8] <= r_rx_byte;
                        r_byte_idx    <= '0;
                    end
                end
                L_WORD: begin
                    if (r_byte_valid) begin
                        r_byte_idx <= r_byte_idx + 1'b1;
                        if (r_byte_idx == 2'd3) begin
                            r_mem_din  <= {r_rx_byte, r_word_asm};
                            r_mem_addr <= BASE_ADDR + r_words;
                        end else begin
                            r_word_asm[8*r_byte_idx +: 8] <= r_rx_byte;
                        end
                    end
                end
                L_WRITE: begin
                    r_words <= w_words_inc;
                end
                default: begin
                end
            endcase

            // Once loading is finished the memory bus is parked at zero.
            if (w_ld_state_next == L_DONE) begin
                r_mem_addr <= '0;
                r_mem_din  <= '0;
            end
        end
    end

    assign mem_en       = (r_ld_state == L_WRITE);
    assign mem_wen      = mem_en;
    assign mem_addr     = r_mem_addr;
    assign mem_din      = r_mem_din;
    assign top_en       = (r_ld_state == L_DONE);
    assign frame_err    = r_frame_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: table of byte streams with expected writes,
// plus hand sequences for glitch rejection, zero-count timing and asynchronous reset.
module tb_uart_program_loader;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rx_a, en_a, wen_a, top_a, ferr_a;
    logic [15:0] addr_a, words_a;
    logic [31:0] din_a;
    logic        rst_b, rx_b, en_b, wen_b, top_b, ferr_b;
    logic [15:0] addr_b, words_b;
    logic [31:0] din_b;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0000)) dut (
        .fast_clk(clk), .reset(rst_a), .uart_rx(rx_a),
        .mem_en(en_a), .mem_wen(wen_a), .mem_addr(addr_a), .mem_din(din_a),
        .top_en(top_a), .frame_err(ferr_a), .words_loaded(words_a)
    );

    uart_program_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0100)) dut_b (
        .fast_clk(clk), .reset(rst_b), .uart_rx(rx_b),
        .mem_en(en_b), .mem_wen(wen_b), .mem_addr(addr_b), .mem_din(din_b),
        .top_en(top_b), .frame_err(ferr_b), .words_loaded(words_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Write-pulse monitors
    logic [15:0] wa_addr[$];
    logic [31:0] wa_din[$];
    logic [15:0] wb_addr[$];
    logic [31:0] wb_din[$];
    int   pulse_a = -1;
    int   rise_a  = -1;
    logic prev_en_a = 1'b0;
    logic prev_top_a = 1'b0;

    always @(negedge clk) begin
        if (en_a) begin
            wa_addr.push_back(addr_a);
            wa_din.push_back(din_a);
            pulse_a <= cyc;
            check("mem_wen_a", {31'd0, wen_a}, {31'd0, en_a});
            check("single_pulse_a", {31'd0, prev_en_a}, 32'd0);
        end
        if (top_a && !prev_top_a) rise_a <= cyc;
        prev_en_a  <= en_a;
        prev_top_a <= top_a;
    end

    always @(negedge clk) begin
        if (en_b) begin
            wb_addr.push_back(addr_b);
            wb_din.push_back(din_b);
            check("mem_wen_b", {31'd0, wen_b}, {31'd0, en_b});
        end
    end

    task automatic drive(input bit sel_b, input logic v);
        if (sel_b) rx_b = v;
        else rx_a = v;
    endtask

    // Called and returns at posedge+1; no idle gap between consecutive bytes.
    task automatic send_byte(input bit sel_b, input logic [7:0] b, input logic stop);
        last_start = cyc;
        drive(sel_b, 1'b0);
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            drive(sel_b, b[i]);
            repeat (CPB) @(posedge clk);
            #1;
        end
        drive(sel_b, stop);
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit sel_b, input int n);
        drive(sel_b, 1'b1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input bit sel_b);
        @(posedge clk);
        #1;
        if (sel_b) begin
            rst_b = 1'b1; wb_addr.delete(); wb_din.delete();
        end else begin
            rst_a = 1'b1; wa_addr.delete(); wa_din.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        if (sel_b) rst_b = 1'b0;
        else rst_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        string        name;
        int           n;
        logic [127:0] stream;   // right-justified, first byte sent is most significant
        logic [15:0]  bad;      // bit i set: byte i is sent with a low stop bit
        int           nwr;
        logic [15:0]  ea0, ea1;
        logic [31:0]  ed0, ed1;
        logic [15:0]  ewords;
        logic         etop;
        logic         eferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        rst_a = 1'b1; rx_a = 1'b1; rst_b = 1'b1; rx_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_en", {31'd0, en_a}, 32'd0);
        check("reset_top", {31'd0, top_a}, 32'd0);
        check("reset_ferr", {31'd0, ferr_a}, 32'd0);
        check("reset_words", {16'd0, words_a}, 32'd0);
        check("reset_addr_din", {addr_a, 16'd0} | din_a, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;

        vecs[0] = '{name:"normal", n:10, stream:128'h0200_7856_3412_EFBE_ADDE, bad:16'h0,
                    nwr:2, ea0:16'h0000, ed0:32'h12345678, ea1:16'h0001, ed1:32'hDEADBEEF,
                    ewords:16'd2, etop:1'b1, eferr:1'b0};
        vecs[1] = '{name:"zero_count", n:2, stream:128'h0000, bad:16'h0,
                    nwr:0, ea0:16'h0, ed0:32'h0, ea1:16'h0, ed1:32'h0,
                    ewords:16'd0, etop:1'b1, eferr:1'b0};
        vecs[2] = '{name:"frame_err", n:7, stream:128'h0100_AA11_2233_44, bad:16'h0004,
                    nwr:1, ea0:16'h0000, ed0:32'h44332211, ea1:16'h0, ed1:32'h0,
                    ewords:16'd1, etop:1'b1, eferr:1'b1};
        vecs[3] = '{name:"partial", n:4, stream:128'h0100_1122, bad:16'h0,
                    nwr:0, ea0:16'h0, ed0:32'h0, ea1:16'h0, ed1:32'h0,
                    ewords:16'd0, etop:1'b0, eferr:1'b0};
        vecs[4] = '{name:"post_done", n:14, stream:128'h0100_0102_0304_AABB_CCDD_EEFF_0011,
                    bad:16'h0, nwr:1, ea0:16'h0000, ed0:32'h04030201, ea1:16'h0, ed1:32'h0,
                    ewords:16'd1, etop:1'b1, eferr:1'b0};

        for (int v = 0; v < 5; v++) begin
            reset_dut(1'b0);
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(1'b0, vecs[v].stream[8*(vecs[v].n-1-i) +: 8], !vecs[v].bad[i]);
            end
            idle(1'b0, 20);
            check({vecs[v].name, "_nwr"}, 32'(wa_addr.size()), 32'(vecs[v].nwr));
            for (int w = 0; w < vecs[v].nwr; w++) begin
                if (w < wa_addr.size()) begin
                    check({vecs[v].name, "_addr"}, {16'd0, wa_addr[w]},
                          {16'd0, (w == 0) ? vecs[v].ea0 : vecs[v].ea1});
                    check({vecs[v].name, "_din"}, wa_din[w], (w == 0) ? vecs[v].ed0 : vecs[v].ed1);
                end
            end
            check({vecs[v].name, "_words"}, {16'd0, words_a}, {16'd0, vecs[v].ewords});
            check({vecs[v].name, "_top"}, {31'd0, top_a}, {31'd0, vecs[v].etop});
            check({vecs[v].name, "_ferr"}, {31'd0, ferr_a}, {31'd0, vecs[v].eferr});
            check({vecs[v].name, "_idle_bus"}, {addr_a, 16'd0} | din_a | {31'd0, en_a}, 32'd0);
            if (vecs[v].nwr > 0) begin
                check({vecs[v].name, "_top_after_pulse"}, 32'(rise_a - pulse_a), 32'd1);
            end
            $display("vector %0s: writes=%0d words=%0d top=%0b ferr=%0b",
                     vecs[v].name, wa_addr.size(), words_a, top_a, ferr_a);
        end

        // Asynchronous reset takes effect mid-cycle while loading is complete.
        @(posedge clk);
        #3;
        rst_a = 1'b1;
        #1;
        check("async_rst_top", {31'd0, top_a}, 32'd0);
        check("async_rst_words", {16'd0, words_a}, 32'd0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        $display("async reset: top=%0b words=%0d", top_a, words_a);

        // Glitch: two-clock low pulse on an idle line.
        reset_dut(1'b0);
        rx_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_a = 1'b1;
        idle(1'b0, 40);
        check("glitch_ferr", {31'd0, ferr_a}, 32'd0);
        check("glitch_top", {31'd0, top_a}, 32'd0);
        check("glitch_nwr", 32'(wa_addr.size()), 32'd0);
        // A spurious byte would have been taken as header byte 0.
        send_byte(1'b0, 8'h00, 1'b1);
        send_byte(1'b0, 8'h00, 1'b1);
        idle(1'b0, 5);
        check("glitch_then_zero_top", {31'd0, top_a}, 32'd1);
        check("zero_top_timing", 32'((rise_a - last_start >= 76) && (rise_a - last_start <= 84)), 32'd1);
        $display("glitch+zero: top=%0b rise_offset=%0d", top_a, rise_a - last_start);

        // Reset in the middle of a word, BASE_ADDR = 0x0100.
        reset_dut(1'b1);
        send_byte(1'b1, 8'h03, 1'b1);
        send_byte(1'b1, 8'h00, 1'b1);
        send_byte(1'b1, 8'hAA, 1'b1);
        send_byte(1'b1, 8'hBB, 1'b1);
        idle(1'b1, 3);
        @(posedge clk);
        #3;
        rst_b = 1'b1;
        #1;
        check("midword_rst_outputs",
              {addr_b, 16'd0} | din_b | {words_b, 16'd0} | {28'd0, en_b, wen_b, top_b, ferr_b}, 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        idle(1'b1, 4);
        send_byte(1'b1, 8'h01, 1'b1);
        send_byte(1'b1, 8'h00, 1'b1);
        send_byte(1'b1, 8'h01, 1'b1);
        send_byte(1'b1, 8'h02, 1'b1);
        send_byte(1'b1, 8'h03, 1'b1);
        send_byte(1'b1, 8'h04, 1'b1);
        idle(1'b1, 20);
        check("midword_nwr", 32'(wb_addr.size()), 32'd1);
        if (wb_addr.size() > 0) begin
            check("midword_addr", {16'd0, wb_addr[0]}, 32'h0000_0100);
            check("midword_din", wb_din[0], 32'h04030201);
        end
        check("midword_top", {31'd0, top_b}, 32'd1);
        check("midword_words", {16'd0, words_b}, 32'd1);
        $display("reset mid-word: writes=%0d top=%0b words=%0d", wb_addr.size(), top_b, words_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
